// File: rtl/beat_sequencer_if.sv
// Control and beat-output bundle between a transport controller and beat_sequencer.
// Define BEAT_SEQ_LOOP_EN to add the level-sensitive loop input.
interface beat_sequencer_if #(
  parameter int unsigned BEAT_W = 12
);
  logic              start;
  logic              pause;
  logic              stop;
`ifdef BEAT_SEQ_LOOP_EN
  logic              loop;
`endif
  logic [BEAT_W-1:0] ibeatNum;
  logic              beat_tick;
  logic              mute;
  logic              playing;
  logic              done;

`ifdef BEAT_SEQ_LOOP_EN
  modport master (output start, pause, stop, loop,
                  input  ibeatNum, beat_tick, mute, playing, done);
  modport slave  (input  start, pause, stop, loop,
                  output ibeatNum, beat_tick, mute, playing, done);
`else
  modport master (output start, pause, stop,
                  input  ibeatNum, beat_tick, mute, playing, done);
  modport slave  (input  start, pause, stop,
                  output ibeatNum, beat_tick, mute, playing, done);
`endif
endinterface

// File: rtl/beat_sequencer.sv
// Tempo-driven beat index generator with play/pause/stop control for the tone ROMs.
// Optional BEAT_SEQ_LOOP_EN: loop=1 wraps to beat 0 at end of song instead of stopping.
module beat_sequencer #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned BEAT_HZ  = 8,
  parameter int unsigned SONG_LEN = 112,
  parameter int unsigned BEAT_W   = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  beat_sequencer_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / BEAT_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(SONG_LEN - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("beat_sequencer: CLK_HZ/BEAT_HZ must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_presc;
  logic [BEAT_W-1:0] r_beat;
  logic              r_tick;
  logic              r_done;
  logic              r_mute;
  logic              r_playing;

  state_t            w_state_nxt;
  logic [PW-1:0]     w_presc_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              w_tick_nxt;
  logic              w_done_nxt;
  logic              w_tick_cond;
  logic              w_loop;

`ifdef BEAT_SEQ_LOOP_EN
  assign w_loop = bus.loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_tick_cond = (r_state == S_PLAY) && (r_presc == PRESC_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_beat_nxt  = r_beat;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (bus.stop) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_beat_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            w_state_nxt = S_PLAY;
            w_presc_nxt = '0;
            w_beat_nxt  = '0;
          end
        end
        S_PLAY: begin
          if (w_tick_cond) begin
            w_presc_nxt = '0;
            if (r_beat != BEAT_LAST) begin
              w_beat_nxt = r_beat + BEAT_W'(1);
              w_tick_nxt = 1'b1;
            end else if (w_loop) begin
              w_beat_nxt = '0;
              w_tick_nxt = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
          // A tick in the pause cycle is still taken; song end outranks pause.
          if (bus.pause && (w_state_nxt == S_PLAY)) begin
            w_state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (bus.start || bus.pause) begin
            w_state_nxt = S_PLAY;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_beat    <= '0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
      r_mute    <= 1'b1;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_beat    <= w_beat_nxt;
      r_tick    <= w_tick_nxt;
      r_done    <= w_done_nxt;
      r_mute    <= (w_state_nxt != S_PLAY);
      r_playing <= (w_state_nxt == S_PLAY);
    end
  end

  assign bus.ibeatNum  = r_beat;
  assign bus.beat_tick = r_tick;
  assign bus.done      = r_done;
  assign bus.mute      = r_mute;
  assign bus.playing   = r_playing;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer (DIV=10, 6-beat song) with a cycle-level reference model.
// Build with BEAT_SEQ_LOOP_EN defined to also exercise looping.
module tb_beat_sequencer;

  localparam int DIV      = 10;
  localparam int SONG_LEN = 6;
  localparam int MD_IDLE  = 0;
  localparam int MD_PLAY  = 1;
  localparam int MD_PAUSE = 2;
  localparam int MD_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  beat_sequencer_if #(.BEAT_W(12)) bus ();

  beat_sequencer #(
    .CLK_HZ  (40),
    .BEAT_HZ (4),
    .SONG_LEN(6),
    .BEAT_W  (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: m_played counts cycles spent on the current beat while playing.
  int m_beat, m_played, m_mode;
  bit m_tick, m_done;

  always @(posedge clk or negedge rst_n) begin : model
    int b, e, md;
    bit t, d, lp;
    if (!rst_n) begin
      m_beat <= 0; m_played <= 0; m_mode <= MD_IDLE; m_tick <= 0; m_done <= 0;
    end else begin
      b = m_beat; e = m_played; md = m_mode; t = 0; d = 0;
`ifdef BEAT_SEQ_LOOP_EN
      lp = bus.loop;
`else
      lp = 0;
`endif
      if (bus.stop) begin
        md = MD_IDLE; b = 0; e = 0;
      end else if (md == MD_IDLE || md == MD_DONE) begin
        if (bus.start) begin md = MD_PLAY; b = 0; e = 0; end
      end else if (md == MD_PAUSE) begin
        if (bus.start || bus.pause) md = MD_PLAY;
      end else begin
        e = e + 1;
        if (e == DIV) begin
          e = 0;
          if (b + 1 < SONG_LEN) begin b = b + 1; t = 1; end
          else if (lp) begin b = 0; t = 1; end
          else begin md = MD_DONE; d = 1; end
        end
        if (bus.pause && md == MD_PLAY) md = MD_PAUSE;
      end
      m_beat <= b; m_played <= e; m_mode <= md; m_tick <= t; m_done <= d;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ibeatNum", int'(bus.ibeatNum), m_beat);
      chk("beat_tick", int'(bus.beat_tick), int'(m_tick));
      chk("done", int'(bus.done), int'(m_done));
      chk("playing", int'(bus.playing), int'(m_mode == MD_PLAY));
      chk("mute", int'(bus.mute), int'(m_mode != MD_PLAY));
    end
  end

  // Counts rising edges until the selected pulse is seen, then realigns to a falling edge.
  task automatic wait_evt(input bit sel_done, input int max, output int n);
    bit found;
    n = 0;
    found = 0;
    while (!found && n < max) begin
      @(posedge clk);
      n++;
      #1;
      found = sel_done ? bus.done : bus.beat_tick;
    end
    if (!found) chk(sel_done ? "done_timeout" : "tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.pause = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ibeatNum"}, int'(bus.ibeatNum), 0);
    chk({tag, "_mute"}, int'(bus.mute), 1);
    chk({tag, "_playing"}, int'(bus.playing), 0);
    chk({tag, "_beat_tick"}, int'(bus.beat_tick), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
`ifdef BEAT_SEQ_LOOP_EN
    bus.loop  = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    pulse_start();
    chk("start_playing", int'(bus.playing), 1);
    chk("start_mute", int'(bus.mute), 0);
    for (int i = 1; i < SONG_LEN; i++) begin
      wait_evt(1'b0, 20, n);
      chk("tempo", n, 10);
      chk("beat_idx", int'(bus.ibeatNum), i);
    end
    wait_evt(1'b1, 20, n);
    chk("done_delay", n, 10);
    chk("done_beat", int'(bus.ibeatNum), 5);
    chk("done_mute", int'(bus.mute), 1);
    chk("done_tick", int'(bus.beat_tick), 0);
    @(negedge clk);
    chk("done_once", int'(bus.done), 0);

    // Restart from DONE, then pause with the prescaler holding 4 on beat 2.
    pulse_start();
    chk("restart_beat", int'(bus.ibeatNum), 0);
    wait_evt(1'b0, 20, n);
    wait_evt(1'b0, 20, n);
    repeat (3) @(negedge clk);
    pulse_pause();
    repeat (50) @(negedge clk);
    chk("pause_hold_beat", int'(bus.ibeatNum), 2);
    chk("pause_mute", int'(bus.mute), 1);
    pulse_pause();
    chk("resume_playing", int'(bus.playing), 1);
    wait_evt(1'b0, 20, n);
    chk("resume_latency", n, 6);
    chk("resume_beat", int'(bus.ibeatNum), 3);

    // Pause lands on the same edge as the tick condition.
    repeat (9) @(negedge clk);
    pulse_pause();
    chk("tickpause_tick", int'(bus.beat_tick), 1);
    chk("tickpause_beat", int'(bus.ibeatNum), 4);
    chk("tickpause_playing", int'(bus.playing), 0);
    pulse_start();
    chk("start_resume", int'(bus.playing), 1);

    repeat (3) @(negedge clk);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    chk("stopstart_beat", int'(bus.ibeatNum), 0);
    chk("stopstart_playing", int'(bus.playing), 0);
    chk("stopstart_mute", int'(bus.mute), 1);

`ifdef BEAT_SEQ_LOOP_EN
    bus.loop = 1'b1;
    pulse_start();
    for (int i = 1; i < SONG_LEN; i++) wait_evt(1'b0, 20, n);
    wait_evt(1'b0, 20, n);
    chk("loop_latency", n, 10);
    chk("loop_beat", int'(bus.ibeatNum), 0);
    chk("loop_tick", int'(bus.beat_tick), 1);
    chk("loop_done", int'(bus.done), 0);
    chk("loop_playing", int'(bus.playing), 1);
    wait_evt(1'b0, 20, n);
    chk("loop_next_beat", int'(bus.ibeatNum), 1);
    bus.loop = 1'b0;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
`endif

    // Asynchronous reset in the middle of a song.
    pulse_start();
    repeat (15) @(negedge clk);
    chk("pre_reset_beat", int'(bus.ibeatNum), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midsong");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", int'(bus.playing), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

endmodule
